cnn_inst_scheduler: RTL and testbench

//  Queues 128-bit CNN instructions written by the host and recognises the control words RESET and START.
//  On START, issues the queued instructions one at a time to cnn_inst_parser, waiting for each to finish.

---
 rtl/cnn_inst_pkg.sv | 46 ++++
 rtl/cnn_inst_scheduler_if.sv | 26 ++
 rtl/cnn_inst_fifo.sv | 66 ++++++
 rtl/cnn_inst_scheduler.sv | 148 ++++++++++++++
 tb/tb_cnn_inst_scheduler.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_inst_pkg.sv
// Shared types and constants for the CNN instruction scheduler:
// instruction layout, control codes, opcodes and FSM state encoding.
package cnn_inst_pkg;

    localparam int unsigned INST_W      = 128;
    localparam int unsigned DEPTH_LOG2  = 4;
    localparam int unsigned ACK_TIMEOUT = 64;

    // Control words carry zero in [INST_W-1:8]; the low byte selects the command.
    localparam logic [7:0] CMD_RESET = 8'h01;
    localparam logic [7:0] CMD_START = 8'h02;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_MULT = 4'h4,
        OP_DOT  = 4'h6,
        OP_CONV = 4'h7,
        OP_POOL = 4'h8,
        OP_TANH = 4'hB,
        OP_GRAY = 4'hC,
        OP_TRAN = 4'hD,
        OP_ADDS = 4'hE
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } sched_state_e;

    function automatic logic [INST_W-1:0] make_inst(
        input opcode_e     op,
        input logic [31:0] src1,
        input logic [31:0] src2,
        input logic [31:0] dst,
        input logic [7:0]  h,
        input logic [7:0]  w,
        input logic [5:0]  kh,
        input logic [5:0]  kw
    );
        return {op, src1, src2, dst, h, w, kh, kw};
    endfunction

endpackage

// File: rtl/cnn_inst_scheduler_if.sv
// Host/parser-facing signal bundle of the instruction scheduler.
interface cnn_inst_scheduler_if #(
    parameter int unsigned INST_W     = 128,
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [INST_W-1:0]   cnn_inst;
    logic                cnn_inst_en;
    logic                parser_ready;
    logic [INST_W-1:0]   parser_inst;
    logic                parser_inst_en;
    logic                busy;
    logic                done;
    logic [DEPTH_LOG2:0] inst_pending;
    logic                ovf_err;
    logic                tmo_err;

    modport slave (
        input  cnn_inst, cnn_inst_en, parser_ready,
        output parser_inst, parser_inst_en, busy, done, inst_pending, ovf_err, tmo_err
    );

    modport master (
        output cnn_inst, cnn_inst_en, parser_ready,
        input  parser_inst, parser_inst_en, busy, done, inst_pending, ovf_err, tmo_err
    );
endinterface

// File: rtl/cnn_inst_fifo.sv
// Synchronous instruction FIFO with first-word-fall-through head, occupancy
// count and a synchronous flush that takes priority over push/pop.
module cnn_inst_fifo #(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cnn_inst_scheduler.sv
// Queues host instructions, decodes RESET/START control words and issues the
// queued batch to the parser one instruction at a time with an ack timeout.
module cnn_inst_scheduler #(
    parameter int unsigned INST_W      = cnn_inst_pkg::INST_W,
    parameter int unsigned DEPTH_LOG2  = cnn_inst_pkg::DEPTH_LOG2,
    parameter int unsigned ACK_TIMEOUT = cnn_inst_pkg::ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cnn_inst_scheduler_if.slave   bus
);
    import cnn_inst_pkg::*;

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    sched_state_e        state;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                is_ctrl;
    logic                cmd_reset;
    logic                cmd_start;
    logic                data_push;
    logic                issue_fire;
    logic                ack_expired;
    logic                inst_complete;

    logic [INST_W-1:0]   fifo_head;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_empty;
    logic                fifo_full;

    logic [INST_W-1:0]   parser_inst;
    logic                parser_inst_en;
    logic                busy;
    logic                done;
    logic                ovf_err;
    logic                tmo_err;

    always_comb begin
        is_ctrl     = (bus.cnn_inst[INST_W-1:8] == '0);
        cmd_reset   = bus.cnn_inst_en && is_ctrl && (bus.cnn_inst[7:0] == CMD_RESET);
        cmd_start   = bus.cnn_inst_en && is_ctrl && (bus.cnn_inst[7:0] == CMD_START);
        data_push   = bus.cnn_inst_en && !is_ctrl;
        issue_fire  = (state == S_ISSUE) && bus.parser_ready && !fifo_empty && !cmd_reset;
        ack_expired = (state == S_WAIT_ACK) && bus.parser_ready
                      && (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
        // A timed-out ack is handled exactly like a normal completion.
        inst_complete = ack_expired || ((state == S_WAIT_DONE) && bus.parser_ready);
    end

    cnn_inst_fifo #(
        .WIDTH      (INST_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (cmd_reset),
        .push      (data_push),
        .push_data (bus.cnn_inst),
        .pop       (issue_fire),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            tmo_cnt        <= '0;
            parser_inst    <= '0;
            parser_inst_en <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ovf_err        <= 1'b0;
            tmo_err        <= 1'b0;
        end else begin
            parser_inst_en <= 1'b0;
            done           <= 1'b0;
            if (data_push && fifo_full) begin
                ovf_err <= 1'b1;
            end

            if (cmd_reset) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                tmo_cnt <= '0;
                ovf_err <= 1'b0;
                tmo_err <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_start) begin
                            if (!fifo_empty) begin
                                state <= S_ISSUE;
                                busy  <= 1'b1;
                            end else begin
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (issue_fire) begin
                            parser_inst    <= fifo_head;
                            parser_inst_en <= 1'b1;
                            tmo_cnt        <= '0;
                            state          <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (!bus.parser_ready) begin
                            state <= S_WAIT_DONE;
                        end else if (ack_expired) begin
                            tmo_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    S_WAIT_DONE: begin
                        state <= S_WAIT_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase

                if (inst_complete) begin
                    if (!fifo_empty) begin
                        state <= S_ISSUE;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.parser_inst    = parser_inst;
    assign bus.parser_inst_en = parser_inst_en;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.inst_pending   = fifo_count;
    assign bus.ovf_err        = ovf_err;
    assign bus.tmo_err        = tmo_err;

endmodule

// File: tb/tb_cnn_inst_scheduler.sv
// Directed self-checking bench for cnn_inst_scheduler with a simple parser model.
module tb_cnn_inst_scheduler;
    import cnn_inst_pkg::*;

    localparam int PARSE_CYCLES = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnn_inst_scheduler_if #(.INST_W(128), .DEPTH_LOG2(4)) bus ();

    cnn_inst_scheduler #(
        .INST_W      (128),
        .DEPTH_LOG2  (4),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_left = 0;
    bit never_ack = 1'b0;
    logic model_ready = 1'b1;
    logic [127:0] issued[$];
    logic [127:0] exp_list[$];

    assign bus.parser_ready = model_ready;

    // Parser: drops ready for PARSE_CYCLES after each issue unless never_ack is set.
    always @(negedge clk) begin
        if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) model_ready = 1'b1;
        end else if (bus.parser_inst_en && !never_ack) begin
            model_ready = 1'b0;
            busy_left = PARSE_CYCLES;
        end
    end

    always @(negedge clk) begin
        if (bus.parser_inst_en) issued.push_back(bus.parser_inst);
        if (bus.done) done_cnt = done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] w);
        bus.cnn_inst = w;
        bus.cnn_inst_en = 1'b1;
        tick();
        bus.cnn_inst_en = 1'b0;
        bus.cnn_inst = '0;
    endtask

    task automatic wait_done(input int start_cnt, input int budget);
        for (int i = 0; i < budget && done_cnt == start_cnt; i++) tick();
    endtask

    task automatic wait_issued(input int n, input int budget);
        for (int i = 0; i < budget && issued.size() < n; i++) tick();
    endtask

    initial begin
        opcode_e ops1[10];
        logic [127:0] w;
        int d0;
        int base;

        ops1 = '{OP_ADDS, OP_GRAY, OP_ADD, OP_ADDI, OP_TANH, OP_DOT, OP_CONV, OP_POOL, OP_MULT, OP_TRAN};
        bus.cnn_inst = '0;
        bus.cnn_inst_en = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_pending", 128'(bus.inst_pending), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_issue_en", 128'(bus.parser_inst_en), 128'd0);
        check("rst_ovf", 128'(bus.ovf_err), 128'd0);
        check("rst_tmo", 128'(bus.tmo_err), 128'd0);
        rst_n = 1'b1;
        tick();

        // 1: ten instructions issued in order
        for (int i = 0; i < 10; i++) begin
            w = make_inst(ops1[i], 32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 8'd28, 8'd28, 6'd3, 6'd3);
            exp_list.push_back(w);
            send(w);
        end
        check("t1_pending10", 128'(bus.inst_pending), 128'd10);
        d0 = done_cnt;
        send(128'(CMD_START));
        check("t1_busy_after_start", 128'(bus.busy), 128'd1);
        check("t1_no_issue_yet", 128'(bus.parser_inst_en), 128'd0);
        tick();
        check("t1_first_issue_en", 128'(bus.parser_inst_en), 128'd1);
        check("t1_first_issue_inst", bus.parser_inst, exp_list[0]);
        check("t1_pending_after_pop", 128'(bus.inst_pending), 128'd9);
        wait_done(d0, 600);
        check("t1_done_once", 128'(done_cnt), 128'(d0 + 1));
        check("t1_issue_count", 128'(issued.size()), 128'd10);
        for (int i = 0; i < 10; i++) check($sformatf("t1_order_%0d", i), issued[i], exp_list[i]);
        tick();
        check("t1_pending0", 128'(bus.inst_pending), 128'd0);
        check("t1_busy_idle", 128'(bus.busy), 128'd0);
        repeat (5) tick();
        check("t1_done_single", 128'(done_cnt), 128'(d0 + 1));

        // 2: overflow and RESET
        base = issued.size();
        for (int i = 0; i < 16; i++) send(make_inst(OP_CONV, 32'h5000 + i, 32'h1, 32'h2, 8'd4, 8'd4, 6'd1, 6'd1));
        check("t2_pending16", 128'(bus.inst_pending), 128'd16);
        check("t2_no_ovf_at_full", 128'(bus.ovf_err), 128'd0);
        send(make_inst(OP_POOL, 32'h6000, 32'h1, 32'h2, 8'd4, 8'd4, 6'd1, 6'd1));
        check("t2_pending_sat", 128'(bus.inst_pending), 128'd16);
        check("t2_ovf_set", 128'(bus.ovf_err), 128'd1);
        send(128'(CMD_RESET));
        check("t2_pending_flushed", 128'(bus.inst_pending), 128'd0);
        check("t2_ovf_cleared", 128'(bus.ovf_err), 128'd0);
        send(128'h7);
        check("t2_ctrl_not_queued", 128'(bus.inst_pending), 128'd0);
        check("t2_no_issue", 128'(issued.size()), 128'(base));

        // 3: START with empty queue
        d0 = done_cnt;
        send(128'(CMD_START));
        check("t3_done_pulse", 128'(bus.done), 128'd1);
        check("t3_not_busy", 128'(bus.busy), 128'd0);
        tick();
        check("t3_done_low", 128'(bus.done), 128'd0);
        check("t3_done_count", 128'(done_cnt), 128'(d0 + 1));
        check("t3_no_issue", 128'(issued.size()), 128'(base));

        // 4: ack timeout
        never_ack = 1'b1;
        exp_list.delete();
        exp_list.push_back(make_inst(OP_DOT, 32'hA0, 32'hA1, 32'hA2, 8'd8, 8'd8, 6'd2, 6'd2));
        exp_list.push_back(make_inst(OP_TANH, 32'hB0, 32'hB1, 32'hB2, 8'd8, 8'd8, 6'd2, 6'd2));
        send(exp_list[0]);
        send(exp_list[1]);
        d0 = done_cnt;
        send(128'(CMD_START));
        tick();
        check("t4_issue_a", bus.parser_inst, exp_list[0]);
        check("t4_issue_a_en", 128'(bus.parser_inst_en), 128'd1);
        repeat (63) tick();
        check("t4_tmo_not_yet", 128'(bus.tmo_err), 128'd0);
        tick();
        check("t4_tmo_set", 128'(bus.tmo_err), 128'd1);
        tick();
        check("t4_issue_b_en", 128'(bus.parser_inst_en), 128'd1);
        check("t4_issue_b", bus.parser_inst, exp_list[1]);
        wait_done(d0, 200);
        check("t4_done", 128'(done_cnt), 128'(d0 + 1));
        check("t4_tmo_sticky", 128'(bus.tmo_err), 128'd1);
        never_ack = 1'b0;
        send(128'(CMD_RESET));
        check("t4_tmo_cleared", 128'(bus.tmo_err), 128'd0);

        // 5: push during WAIT_DONE of the last entry
        base = issued.size();
        exp_list.delete();
        exp_list.push_back(make_inst(OP_ADD, 32'hC0, 32'hC1, 32'hC2, 8'd2, 8'd2, 6'd1, 6'd1));
        exp_list.push_back(make_inst(OP_MULT, 32'hD0, 32'hD1, 32'hD2, 8'd2, 8'd2, 6'd1, 6'd1));
        exp_list.push_back(make_inst(OP_GRAY, 32'hE0, 32'hE1, 32'hE2, 8'd2, 8'd2, 6'd1, 6'd1));
        send(exp_list[0]);
        send(exp_list[1]);
        d0 = done_cnt;
        send(128'(CMD_START));
        wait_issued(base + 2, 200);
        check("t5_two_issued", 128'(issued.size()), 128'(base + 2));
        repeat (5) tick();
        send(exp_list[2]);
        check("t5_no_early_done", 128'(done_cnt), 128'(d0));
        check("t5_still_busy", 128'(bus.busy), 128'd1);
        wait_done(d0, 200);
        check("t5_done_once", 128'(done_cnt), 128'(d0 + 1));
        check("t5_issue_count", 128'(issued.size()), 128'(base + 3));
        check("t5_late_entry", issued[base + 2], exp_list[2]);

        // 6: async reset mid-batch
        repeat (3) tick();
        base = issued.size();
        for (int i = 0; i < 8; i++) send(make_inst(OP_ADDI, 32'hF00 + i, 32'h1, 32'h2, 8'd3, 8'd3, 6'd1, 6'd1));
        send(128'(CMD_START));
        wait_issued(base + 3, 200);
        check("t6_three_issued", 128'(issued.size()), 128'(base + 3));
        check("t6_pending5", 128'(bus.inst_pending), 128'd5);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("t6_busy_cleared", 128'(bus.busy), 128'd0);
        check("t6_pending_cleared", 128'(bus.inst_pending), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        d0 = done_cnt;
        base = issued.size();
        send(128'(CMD_START));
        check("t6_empty_done", 128'(bus.done), 128'd1);
        repeat (30) tick();
        check("t6_no_issue", 128'(issued.size()), 128'(base));
        check("t6_done_count", 128'(done_cnt), 128'(d0 + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
